alu_issue_wb: RTL and testbench

ALU_ISSUE_WB -- requirements
Module: alu_issue_wb

---
 rtl/alu_issue_wb.sv | 156 +++++++++++++++
 tb/tb_alu_issue_wb.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_wb.sv
// alu_issue_wb
//   Issue and writeback wrapper around an external combinational ALU.
//   It holds an 8 x 16 register file and runs a two-stage pipeline:
//     EX : registered operands/opcode driven to the ALU (alu_a/alu_b/alu_op),
//          plus ex_valid/ex_rd for the instruction in flight.
//     WB : alu_y captured into wb_data, written to regfile[ex_rd], and the
//          flags are updated.
//   BYPASS = 1 forwards the in-flight ALU result to a dependent request.
//   BYPASS = 0 stalls that request for one cycle instead.
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid / req_ready   : instruction handshake
//   req_op, req_rd/ra/rb    : opcode, destination and source registers
//   alu_a, alu_b, alu_op    : registered ALU inputs
//   alu_y                   : ALU result for the current alu_a/alu_b/alu_op
//   wb_valid, wb_rd, wb_data: retired instruction (pulses once per retire)
//   flag_z, flag_n          : zero/negative flags of the last retired result
//   dbg_sel, dbg_data       : combinational register file read port
//
// Handshake: a request is taken on a rising edge where req_valid &&
// req_ready. req_ready depends only on the EX state and on req_ra/req_rb,
// never on req_valid. It is low while rst_n is low.

module alu_issue_wb #(
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [2:0]  req_rd,
    input  logic [2:0]  req_ra,
    input  logic [2:0]  req_rb,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_y,
    output logic        wb_valid,
    output logic [2:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        flag_z,
    output logic        flag_n,
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg_data
);

    logic [15:0] regfile_q [8];
    logic [15:0] regfile_d [8];
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        ex_valid_q, ex_valid_d;
    logic [2:0]  ex_rd_q, ex_rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [2:0]  wb_rd_q, wb_rd_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_n_q, flag_n_d;

    logic [15:0] opnd_a;
    logic [15:0] opnd_b;
    logic        hazard;
    logic        accept;

    // Operand selection and issue control. The EX instruction writes the
    // register file only at the next edge, so a source that matches ex_rd
    // either takes alu_y directly (bypass) or waits one cycle (stall).
    always_comb begin
        opnd_a = regfile_q[req_ra];
        opnd_b = regfile_q[req_rb];
        if ((BYPASS != 0) && ex_valid_q && (ex_rd_q == req_ra)) begin
            opnd_a = alu_y;
        end
        if ((BYPASS != 0) && ex_valid_q && (ex_rd_q == req_rb)) begin
            opnd_b = alu_y;
        end
        hazard    = (BYPASS == 0) && ex_valid_q &&
                    ((ex_rd_q == req_ra) || (ex_rd_q == req_rb));
        req_ready = rst_n && !hazard;
        accept    = req_valid && req_ready;
    end

    always_comb begin
        regfile_d  = regfile_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        ex_rd_d    = ex_rd_q;
        ex_valid_d = accept;
        wb_valid_d = ex_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        flag_z_d   = flag_z_q;
        flag_n_d   = flag_n_q;

        if (accept) begin
            alu_a_d  = opnd_a;
            alu_b_d  = opnd_b;
            alu_op_d = req_op;
            ex_rd_d  = req_rd;
        end

        if (ex_valid_q) begin
            regfile_d[ex_rd_q] = alu_y;
            wb_rd_d            = ex_rd_q;
            wb_data_d          = alu_y;
            flag_z_d           = (alu_y == 16'h0000);
            flag_n_d           = alu_y[15];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regfile_q[i] <= 16'h0000;
            end
            alu_a_q    <= 16'h0000;
            alu_b_q    <= 16'h0000;
            alu_op_q   <= 3'b000;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= 3'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 3'd0;
            wb_data_q  <= 16'h0000;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regfile_q[i] <= regfile_d[i];
            end
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign flag_z   = flag_z_q;
    assign flag_n   = flag_n_q;
    assign dbg_data = regfile_q[dbg_sel];

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb. Two instances share clock and reset:
//   index 0 : BYPASS = 1
//   index 1 : BYPASS = 0
// Each instance has its own inputs and its own ALU model. Op 110 returns a
// bench-supplied immediate that travels alongside the instruction, so
// registers can be loaded with known values.
module tb_alu_issue_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [2:0]  req_op [2];
    logic [2:0]  req_rd [2];
    logic [2:0]  req_ra [2];
    logic [2:0]  req_rb [2];
    logic [15:0] alu_a [2];
    logic [15:0] alu_b [2];
    logic [2:0]  alu_op [2];
    logic [15:0] alu_y [2];
    logic        wb_valid [2];
    logic [2:0]  wb_rd [2];
    logic [15:0] wb_data [2];
    logic        flag_z [2];
    logic        flag_n [2];
    logic [2:0]  dbg_sel [2];
    logic [15:0] dbg_data [2];
    logic [15:0] imm [2];
    logic [15:0] imm_ex [2];

    logic [20:0] wb_q [2][$];   // {rd, data, z, n} per observed writeback
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_wb #(.BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op[0]), .req_rd(req_rd[0]), .req_ra(req_ra[0]), .req_rb(req_rb[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_y(alu_y[0]),
        .wb_valid(wb_valid[0]), .wb_rd(wb_rd[0]), .wb_data(wb_data[0]),
        .flag_z(flag_z[0]), .flag_n(flag_n[0]),
        .dbg_sel(dbg_sel[0]), .dbg_data(dbg_data[0])
    );

    alu_issue_wb #(.BYPASS(0)) u_stl (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op[1]), .req_rd(req_rd[1]), .req_ra(req_ra[1]), .req_rb(req_rb[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_y(alu_y[1]),
        .wb_valid(wb_valid[1]), .wb_rd(wb_rd[1]), .wb_data(wb_data[1]),
        .flag_z(flag_z[1]), .flag_n(flag_n[1]),
        .dbg_sel(dbg_sel[1]), .dbg_data(dbg_data[1])
    );

    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] im);
        logic [31:0] p;
        p = {16'h0000, a} * {16'h0000, b};
        case (op)
            3'b000:  return a + b;
            3'b001:  return a ^ b;
            3'b010:  return a - b;
            3'b011:  return a & b;
            3'b100:  return ~b;
            3'b101:  return a | b;
            3'b110:  return im;
            default: return p[15:0];
        endcase
    endfunction

    assign alu_y[0] = alu_f(alu_op[0], alu_a[0], alu_b[0], imm_ex[0]);
    assign alu_y[1] = alu_f(alu_op[1], alu_a[1], alu_b[1], imm_ex[1]);

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (req_valid[u] && req_ready[u]) imm_ex[u] <= imm[u];
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (wb_valid[u]) wb_q[u].push_back({wb_rd[u], wb_data[u], flag_z[u], flag_n[u]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input int u, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb, output int stalls);
        req_valid[u] = 1'b1;
        req_op[u] = op; req_rd[u] = rd; req_ra[u] = ra; req_rb[u] = rb;
        stalls = 0;
        #1;
        while (!req_ready[u] && stalls < 8) begin
            @(negedge clk); #1;
            stalls++;
        end
        checks++;
        if (req_ready[u] !== 1'b1) begin
            failures++;
            $display("FAIL issue_timeout u=%0d: req_ready=%b required 1 within 8 cycles", u, req_ready[u]);
        end
        @(negedge clk);
        req_valid[u] = 1'b0;
    endtask

    task automatic preload(input int u, input logic [2:0] rd, input logic [15:0] val);
        int st;
        imm[u] = val;
        issue(u, 3'b110, rd, 3'd0, 3'd0, st);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_op[u] = 3'd0; req_rd[u] = 3'd0;
            req_ra[u] = 3'd0; req_rb[u] = 3'd0; dbg_sel[u] = 3'd0; imm[u] = 16'h0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (req_ready[u] !== 1'b0) begin failures++; $display("FAIL rst_ready u=%0d: got %b want 0", u, req_ready[u]); end
            checks++;
            if ({wb_valid[u], flag_z[u], flag_n[u]} !== 3'b000) begin
                failures++; $display("FAIL rst_wb_flags u=%0d: got %b want 000", u, {wb_valid[u], flag_z[u], flag_n[u]});
            end
            checks++;
            if ({alu_a[u], alu_b[u], alu_op[u], wb_rd[u], wb_data[u]} !== 54'd0) begin
                failures++; $display("FAIL rst_regs u=%0d: a=%h b=%h op=%b rd=%0d d=%h want all 0",
                                     u, alu_a[u], alu_b[u], alu_op[u], wb_rd[u], wb_data[u]);
            end
            for (int r = 0; r < 8; r++) begin
                dbg_sel[u] = r[2:0];
                #1;
                checks++;
                if (dbg_data[u] !== 16'h0000) begin
                    failures++; $display("FAIL rst_rf u=%0d r%0d: got %h want 0000", u, r, dbg_data[u]);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (req_ready[u] !== 1'b1) begin failures++; $display("FAIL post_rst_ready u=%0d: got %b want 1", u, req_ready[u]); end
        end
    endtask

    task automatic test_add(input int u);
        int st;
        @(negedge clk);
        preload(u, 3'd1, 16'd5);
        preload(u, 3'd2, 16'd3);
        issue(u, 3'b000, 3'd3, 3'd1, 3'd2, st);
        checks++;
        if (wb_valid[u] !== 1'b0) begin failures++; $display("FAIL add_early u=%0d: wb_valid=%b want 0", u, wb_valid[u]); end
        dbg_sel[u] = 3'd3;
        #1;
        checks++;
        if (dbg_data[u] !== 16'h0000) begin failures++; $display("FAIL add_dbg_old u=%0d: got %h want 0000", u, dbg_data[u]); end
        @(negedge clk);
        checks++;
        if ({wb_valid[u], wb_rd[u], wb_data[u], flag_z[u], flag_n[u]} !== {1'b1, 3'd3, 16'd8, 1'b0, 1'b0}) begin
            failures++; $display("FAIL add_wb u=%0d: v=%b rd=%0d d=%h z=%b n=%b want v=1 rd=3 d=0008 z=0 n=0",
                                 u, wb_valid[u], wb_rd[u], wb_data[u], flag_z[u], flag_n[u]);
        end
        #1;
        checks++;
        if (dbg_data[u] !== 16'd8) begin failures++; $display("FAIL add_dbg_new u=%0d: got %h want 0008", u, dbg_data[u]); end
        @(negedge clk);
        checks++;
        if (wb_valid[u] !== 1'b0) begin failures++; $display("FAIL add_pulse u=%0d: wb_valid=%b want 0", u, wb_valid[u]); end
    endtask

    task automatic test_back_to_back(input int u);
        int st_a, st_b;
        logic [20:0] e0, e1;
        @(negedge clk);
        #1;
        wb_q[u].delete();
        @(negedge clk);
        issue(u, 3'b010, 3'd4, 3'd1, 3'd2, st_a);
        issue(u, 3'b001, 3'd5, 3'd4, 3'd4, st_b);
        checks++;
        if (st_b !== ((u == 0) ? 0 : 1)) begin
            failures++; $display("FAIL b2b_stall u=%0d: stalls=%0d want %0d", u, st_b, (u == 0) ? 0 : 1);
        end
        checks++;
        if ({alu_a[u], alu_b[u]} !== {16'd2, 16'd2}) begin
            failures++; $display("FAIL b2b_opnd u=%0d: a=%h b=%h want 0002 0002", u, alu_a[u], alu_b[u]);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (wb_q[u].size() != 2) begin
            failures++; $display("FAIL b2b_count u=%0d: got %0d writebacks want 2", u, wb_q[u].size());
        end else begin
            e0 = wb_q[u][0];
            e1 = wb_q[u][1];
            checks++;
            if (e0 !== {3'd4, 16'd2, 1'b0, 1'b0}) begin failures++; $display("FAIL b2b_first u=%0d: got %h want %h", u, e0, {3'd4, 16'd2, 1'b0, 1'b0}); end
            checks++;
            if (e1 !== {3'd5, 16'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL b2b_second u=%0d: got %h want %h", u, e1, {3'd5, 16'd0, 1'b1, 1'b0}); end
        end
    endtask

    task automatic test_not_b(input int u);
        int st;
        @(negedge clk);
        issue(u, 3'b100, 3'd6, 3'd1, 3'd0, st);
        @(negedge clk);
        checks++;
        if ({wb_rd[u], wb_data[u], flag_z[u], flag_n[u]} !== {3'd6, 16'hFFFF, 1'b0, 1'b1}) begin
            failures++; $display("FAIL not_wb u=%0d: rd=%0d d=%h z=%b n=%b want rd=6 d=ffff z=0 n=1",
                                 u, wb_rd[u], wb_data[u], flag_z[u], flag_n[u]);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({wb_valid[u], flag_z[u], flag_n[u]} !== 3'b001) begin
            failures++; $display("FAIL flag_hold u=%0d: v/z/n=%b want 001", u, {wb_valid[u], flag_z[u], flag_n[u]});
        end
    endtask

    task automatic test_mul_wrap(input int u);
        int st;
        @(negedge clk);
        preload(u, 3'd1, 16'h0100);
        preload(u, 3'd2, 16'h0100);
        issue(u, 3'b111, 3'd7, 3'd1, 3'd2, st);
        @(negedge clk);
        checks++;
        if ({wb_rd[u], wb_data[u], flag_z[u], flag_n[u]} !== {3'd7, 16'h0000, 1'b1, 1'b0}) begin
            failures++; $display("FAIL mul_wrap u=%0d: rd=%0d d=%h z=%b n=%b want rd=7 d=0000 z=1 n=0",
                                 u, wb_rd[u], wb_data[u], flag_z[u], flag_n[u]);
        end
    endtask

    task automatic test_self_dep(input int u);
        int st;
        @(negedge clk);
        issue(u, 3'b000, 3'd2, 3'd2, 3'd1, st);
        @(negedge clk);
        checks++;
        if ({wb_rd[u], wb_data[u], flag_z[u]} !== {3'd2, 16'h0200, 1'b0}) begin
            failures++; $display("FAIL self_dep u=%0d: rd=%0d d=%h z=%b want rd=2 d=0200 z=0", u, wb_rd[u], wb_data[u], flag_z[u]);
        end
        @(negedge clk);
        checks++;
        if ({alu_a[u], alu_b[u], alu_op[u]} !== {16'h0100, 16'h0100, 3'b000}) begin
            failures++; $display("FAIL ex_hold u=%0d: a=%h b=%h op=%b want 0100 0100 000", u, alu_a[u], alu_b[u], alu_op[u]);
        end
        dbg_sel[u] = 3'd2;
        #1;
        checks++;
        if (dbg_data[u] !== 16'h0200) begin failures++; $display("FAIL self_dep_rf u=%0d: got %h want 0200", u, dbg_data[u]); end
    endtask

    task automatic test_reset_mid();
        int st;
        @(negedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            wb_q[u].delete();
            imm[u] = 16'h1234;
            req_valid[u] = 1'b1; req_op[u] = 3'b110; req_rd[u] = 3'd6; req_ra[u] = 3'd0; req_rb[u] = 3'd0;
        end
        @(negedge clk);
        for (int u = 0; u < 2; u++) req_valid[u] = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({req_ready[u], wb_valid[u]} !== 2'b00) begin
                failures++; $display("FAIL mid_rst_ready u=%0d: ready/wb_valid=%b want 00", u, {req_ready[u], wb_valid[u]});
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        imm[0] = 16'd7;
        issue(0, 3'b110, 3'd3, 3'd0, 3'd0, st);
        checks++;
        if (st != 0) begin failures++; $display("FAIL first_accept: stalls=%0d want 0", st); end
        @(negedge clk);
        #1;
        checks++;
        if (wb_q[0].size() != 1 || wb_q[0][0] !== {3'd3, 16'd7, 1'b0, 1'b0}) begin
            failures++; $display("FAIL first_wb: count=%0d want 1 entry rd=3 d=0007", wb_q[0].size());
        end
        checks++;
        if (wb_q[1].size() != 0) begin failures++; $display("FAIL mid_rst_nowb: count=%0d want 0", wb_q[1].size()); end
        for (int u = 0; u < 2; u++) begin
            dbg_sel[u] = 3'd6;
            #1;
            checks++;
            if (dbg_data[u] !== 16'h0000) begin failures++; $display("FAIL mid_rst_rf u=%0d: r6=%h want 0000", u, dbg_data[u]); end
        end
    endtask

    initial begin
        test_reset();
        for (int u = 0; u < 2; u++) begin
            test_add(u);
            test_back_to_back(u);
            test_not_b(u);
            test_mul_wrap(u);
            test_self_dep(u);
        end
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
